// File: rtl/serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// serial_magnitude_comparator
//
// Digit-serial magnitude comparator. Operands are captured on an accepted
// start and examined one D-bit digit per clock, most significant digit first.
// The comparison stops at the first differing digit. The result is reported on
// EQ/GT/LT together with a one-cycle done pulse.
//
// Handshake: start is sampled only while busy=0. A start seen at a rising edge
// in IDLE is accepted at that edge. busy is high for every RUN cycle. done
// pulses for one cycle when a new result becomes visible. busy is already low
// in that cycle, so a new start may be presented there and is accepted at the
// next edge.
//
// Optional feature macro: SIGNED_CMP_EN
//   When defined, the signed_mode input is added. It is captured with the
//   operands. When it is 1, the operands are compared as two's complement:
//   the top bit of the most significant digit is inverted before the compare.
//   When not defined, every compare is unsigned.
//
// Parameters:
//   N : operand width in bits (integer multiple of D)
//   D : digit width examined per clock (1 <= D <= N)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   request a comparison (sampled when busy=0)
//   a, b        in   N-bit operands, captured on accepted start
//   signed_mode in   two's-complement compare (only with SIGNED_CMP_EN)
//   busy        out  comparison in progress (state == RUN)
//   done        out  one-cycle pulse, new result valid
//   EQ, GT, LT  out  a == b, a > b, a < b; held until next accepted start
// -----------------------------------------------------------------------------
module serial_magnitude_comparator #(
  parameter int N = 8,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SIGNED_CMP_EN
  input  logic         signed_mode,
`endif
  output logic         busy,
  output logic         done,
  output logic         EQ,
  output logic         GT,
  output logic         LT
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_a, r_b, w_a_nxt, w_b_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_done, w_done_nxt;
  logic          r_eq, w_eq_nxt;
  logic          r_gt, w_gt_nxt;
  logic          r_lt, w_lt_nxt;
  logic          w_inv_top;
  logic [D-1:0]  w_dig_a, w_dig_b;

`ifdef SIGNED_CMP_EN
  logic r_signed, w_signed_nxt;
  // In the most significant digit, the sign bit is inverted. This turns a
  // two's-complement ordering into an unsigned ordering.
  assign w_inv_top = r_signed && (r_cnt == '0);
`else
  assign w_inv_top = 1'b0;
`endif

  // The current digit is always the top D bits of the shift registers.
  always_comb begin
    w_dig_a = r_a[N-1 -: D];
    w_dig_b = r_b[N-1 -: D];
    w_dig_a[D-1] = w_dig_a[D-1] ^ w_inv_top;
    w_dig_b[D-1] = w_dig_b[D-1] ^ w_inv_top;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
`ifdef SIGNED_CMP_EN
      r_signed <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_eq    <= w_eq_nxt;
      r_gt    <= w_gt_nxt;
      r_lt    <= w_lt_nxt;
`ifdef SIGNED_CMP_EN
      r_signed <= w_signed_nxt;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_eq_nxt    = r_eq;
    w_gt_nxt    = r_gt;
    w_lt_nxt    = r_lt;
`ifdef SIGNED_CMP_EN
    w_signed_nxt = r_signed;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_cnt_nxt   = '0;
          w_eq_nxt    = 1'b0;
          w_gt_nxt    = 1'b0;
          w_lt_nxt    = 1'b0;
          w_state_nxt = RUN;
`ifdef SIGNED_CMP_EN
          w_signed_nxt = signed_mode;
`endif
        end
      end
      RUN: begin
        if (w_dig_a != w_dig_b) begin
          // The first differing digit decides the result.
          w_gt_nxt    = (w_dig_a > w_dig_b);
          w_lt_nxt    = (w_dig_a < w_dig_b);
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == LAST_DIG) begin
          w_eq_nxt    = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_a_nxt   = r_a << D;
          w_b_nxt   = r_b << D;
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign EQ   = r_eq;
  assign GT   = r_gt;
  assign LT   = r_lt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// -----------------------------------------------------------------------------
// Testbench for serial_magnitude_comparator (N=8, D=2).
// Directed vectors with hand-computed expectations, plus a strided sweep
// checked against a reference compare. Define SIGNED_CMP_EN to also exercise
// signed mode.
// -----------------------------------------------------------------------------
module tb_serial_magnitude_comparator;

  localparam int N = 8;
  localparam int D = 2;
  localparam int NDIG = N / D;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       signed_mode;
  logic       busy, done, EQ, GT, LT;

  int n_checks;
  int n_fail;

  serial_magnitude_comparator #(.N(N), .D(D)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .a(a),
    .b(b),
`ifdef SIGNED_CMP_EN
    .signed_mode(signed_mode),
`endif
    .busy(busy),
    .done(done),
    .EQ(EQ),
    .GT(GT),
    .LT(LT)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // {EQ,GT,LT} for an unsigned compare
  function automatic logic [2:0] ref_res(input logic [7:0] x, input logic [7:0] y);
    if (x == y) return 3'b100;
    if (x > y)  return 3'b010;
    return 3'b001;
  endfunction

  // RUN cycles: index of first differing digit + 1, or NDIG if all equal
  function automatic int ref_runs(input logic [7:0] x, input logic [7:0] y);
    for (int j = 0; j < NDIG; j++) begin
      if (x[7-2*j -: 2] != y[7-2*j -: 2]) return j + 1;
    end
    return NDIG;
  endfunction

  // ---------------- driver ----------------
  // Presents one start pulse. On return the bench is in the done cycle
  // (or the wait bound expired). run_cyc counts the cycles with busy high.
  task automatic do_cmp(input logic [7:0] av, input logic [7:0] bv,
                        output int run_cyc, output logic timed_out);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_cyc = 0;
    timed_out = 1'b0;
    while (!done && !timed_out) begin
      if (busy) run_cyc++;
      @(posedge clk); #1;
      if (run_cyc > 20) timed_out = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    signed_mode = 1'b0;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (EQ !== 1'b0) begin n_fail++; $display("FAIL reset_eq got=%b exp=0", EQ); end
    n_checks++; if (GT !== 1'b0) begin n_fail++; $display("FAIL reset_gt got=%b exp=0", GT); end
    n_checks++; if (LT !== 1'b0) begin n_fail++; $display("FAIL reset_lt got=%b exp=0", LT); end
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_equal();
    int rc;
    logic to;
    do_cmp(8'hA5, 8'hA5, rc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL eq_timeout got=%b exp=0", to); end
    n_checks++; if (rc !== 4) begin n_fail++; $display("FAIL eq_busy_cycles got=%0d exp=4", rc); end
    n_checks++; if ({EQ, GT, LT} !== 3'b100) begin n_fail++; $display("FAIL eq_result got=%b exp=100", {EQ, GT, LT}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL eq_busy_in_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL eq_done_width got=%b exp=0", done); end
    n_checks++; if ({EQ, GT, LT} !== 3'b100) begin n_fail++; $display("FAIL eq_hold got=%b exp=100", {EQ, GT, LT}); end
  endtask

  task automatic test_early_term();
    int rc;
    logic to;
    do_cmp(8'h80, 8'h7F, rc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL gt_timeout got=%b exp=0", to); end
    n_checks++; if (rc !== 1) begin n_fail++; $display("FAIL gt_busy_cycles got=%0d exp=1", rc); end
    n_checks++; if ({EQ, GT, LT} !== 3'b010) begin n_fail++; $display("FAIL gt_result got=%b exp=010", {EQ, GT, LT}); end
    do_cmp(8'h34, 8'h35, rc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL lt_timeout got=%b exp=0", to); end
    n_checks++; if (rc !== 4) begin n_fail++; $display("FAIL lt_busy_cycles got=%0d exp=4", rc); end
    n_checks++; if ({EQ, GT, LT} !== 3'b001) begin n_fail++; $display("FAIL lt_result got=%b exp=001", {EQ, GT, LT}); end
  endtask

  task automatic test_back_to_back();
    int rc;
    logic to;
    // 0x10 vs 0x20 differ in digit 1 (01 < 10): LT after 2 RUN cycles
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    @(posedge clk); #1;
    // keep start high with different operands while busy
    a = 8'hFF;
    b = 8'h00;
    rc = 0;
    to = 1'b0;
    while (!done && !to) begin
      if (busy) rc++;
      @(posedge clk); #1;
      if (rc > 20) to = 1'b1;
    end
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout got=%b exp=0", to); end
    n_checks++; if (rc !== 2) begin n_fail++; $display("FAIL b2b_first_cycles got=%0d exp=2", rc); end
    n_checks++; if ({EQ, GT, LT} !== 3'b001) begin n_fail++; $display("FAIL b2b_first_result got=%b exp=001", {EQ, GT, LT}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_done got=%b exp=0", busy); end
    // start still high in the done cycle: accepted at this edge, no gap
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    n_checks++; if ({done, EQ, GT, LT} !== 4'b0000) begin n_fail++; $display("FAIL b2b_clear got=%b exp=0000", {done, EQ, GT, LT}); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    n_checks++; if ({EQ, GT, LT} !== 3'b010) begin n_fail++; $display("FAIL b2b_second_result got=%b exp=010", {EQ, GT, LT}); end
  endtask

  task automatic test_reset_mid_run();
    logic saw;
    a = 8'hA5;
    b = 8'hA5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
    n_checks++; if ({EQ, GT, LT} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags got=%b exp=000", {EQ, GT, LT}); end
    #2 reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got=%b exp=0", saw); end
  endtask

  task automatic test_sweep();
    int rc, max_edges;
    logic to;
    logic [7:0] av, bv;
    logic [7:0] edge_a[4];
    logic [7:0] edge_b[4];
    edge_a = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    edge_b = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    max_edges = 0;
    for (int k = 0; k < 4; k++) begin
      do_cmp(edge_a[k], edge_b[k], rc, to);
      n_checks++;
      if ({EQ, GT, LT} !== ref_res(edge_a[k], edge_b[k]) || rc !== ref_runs(edge_a[k], edge_b[k]) || to) begin
        n_fail++;
        $display("FAIL sweep_edge a=%h b=%h got=%b/%0d exp=%b/%0d", edge_a[k], edge_b[k],
                 {EQ, GT, LT}, rc, ref_res(edge_a[k], edge_b[k]), ref_runs(edge_a[k], edge_b[k]));
      end
      if (rc + 1 > max_edges) max_edges = rc + 1;
    end
    for (int i = 0; i < 256; i += 17) begin
      for (int j = 0; j < 256; j += 13) begin
        av = 8'(i);
        bv = 8'(j);
        do_cmp(av, bv, rc, to);
        n_checks++;
        if ({EQ, GT, LT} !== ref_res(av, bv) || rc !== ref_runs(av, bv) || to) begin
          n_fail++;
          $display("FAIL sweep a=%h b=%h got=%b/%0d exp=%b/%0d", av, bv,
                   {EQ, GT, LT}, rc, ref_res(av, bv), ref_runs(av, bv));
        end
        if (rc + 1 > max_edges) max_edges = rc + 1;
      end
    end
    n_checks++; if (max_edges !== NDIG + 1) begin n_fail++; $display("FAIL sweep_max_latency got=%0d exp=%0d", max_edges, NDIG + 1); end
  endtask

`ifdef SIGNED_CMP_EN
  task automatic test_signed();
    int rc;
    logic to;
    signed_mode = 1'b1;
    do_cmp(8'h80, 8'h7F, rc, to);
    n_checks++; if ({EQ, GT, LT} !== 3'b001 || rc !== 1 || to) begin n_fail++; $display("FAIL signed_80_7f got=%b/%0d exp=001/1", {EQ, GT, LT}, rc); end
    do_cmp(8'hFE, 8'hFF, rc, to);
    n_checks++; if ({EQ, GT, LT} !== 3'b001 || rc !== 4 || to) begin n_fail++; $display("FAIL signed_fe_ff got=%b/%0d exp=001/4", {EQ, GT, LT}, rc); end
    signed_mode = 1'b0;
    do_cmp(8'h80, 8'h7F, rc, to);
    n_checks++; if ({EQ, GT, LT} !== 3'b010 || rc !== 1 || to) begin n_fail++; $display("FAIL unsigned_80_7f got=%b/%0d exp=010/1", {EQ, GT, LT}, rc); end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_equal();
    test_early_term();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
`ifdef SIGNED_CMP_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
